// File: rtl/tim_vseq_pkg.sv
// -----------------------------------------------------------------------------
// tim_vseq_pkg
// Shared definitions for the vertical/frame sequencer: sequencer state
// encoding, idle CCD clock levels, default frame geometry and a decoder that
// maps a state to its clock/status output levels.
// No ports (package).
// -----------------------------------------------------------------------------
package tim_vseq_pkg;

  // Default frame geometry and timing.
  localparam int NLINES_DEF = 1644;
  localparam int NVDUM_DEF  = 4;
  localparam int TV_DEF     = 24;
  localparam int TXFER_DEF  = 200;
  localparam int CW_DEF     = 24;
  localparam int LNW        = 12;   // line_num width

  // Clock levels held while the sequencer is idle (and during exposure).
  localparam logic IDLE_V1 = 1'b0;
  localparam logic IDLE_V2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_EXPOSE = 3'd2,
    ST_XFER   = 3'd3,
    ST_VSH_A  = 3'd4,
    ST_VSH_B  = 3'd5,
    ST_LREAD  = 3'd6,
    ST_DONE   = 3'd7
  } vseq_state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic vact;
    logic v1;
    logic v2;
    logic v3;
    logic sub;
  } vseq_outs_t;

  // Output levels for a state. The caller registers the result using the
  // next state, so each output is valid for exactly the cycles spent in s.
  function automatic vseq_outs_t state_outs(input vseq_state_t s);
    vseq_outs_t o;
    o.busy = 1'b1;
    o.done = 1'b0;
    o.vact = 1'b0;
    o.v1   = IDLE_V1;
    o.v2   = IDLE_V2;
    o.v3   = 1'b0;
    o.sub  = 1'b0;
    case (s)
      ST_IDLE:   o.busy = 1'b0;
      ST_FLUSH:  o.sub  = 1'b1;
      ST_EXPOSE: ;
      ST_XFER: begin
        o.v1 = 1'b1;
        o.v2 = 1'b0;
        o.v3 = 1'b1;
      end
      ST_VSH_A: begin
        o.v1 = 1'b1;
        o.v2 = 1'b0;
      end
      ST_VSH_B:  ;
      ST_LREAD:  o.vact = 1'b1;
      ST_DONE:   o.done = 1'b1;
      default:   o.busy = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tim_vseq_if.sv
// -----------------------------------------------------------------------------
// tim_vseq_if
// Control/status and CCD clock bundle of the vertical sequencer.
//   master : capture control + horizontal FSM side (drives start, abort,
//            exp_time, line_done; observes everything else)
//   slave  : the sequencer itself
// Signals: start, abort, exp_time[CW], line_done, busy, done, vact,
//          v1, v2, v3, sub, frame_valid, line_num[12].
// -----------------------------------------------------------------------------
interface tim_vseq_if import tim_vseq_pkg::*; #(
  parameter int CW = CW_DEF
);
  logic           start;
  logic           abort;
  logic [CW-1:0]  exp_time;
  logic           line_done;
  logic           busy;
  logic           done;
  logic           vact;
  logic           v1;
  logic           v2;
  logic           v3;
  logic           sub;
  logic           frame_valid;
  logic [LNW-1:0] line_num;

  modport master (
    output start, abort, exp_time, line_done,
    input  busy, done, vact, v1, v2, v3, sub, frame_valid, line_num
  );

  modport slave (
    input  start, abort, exp_time, line_done,
    output busy, done, vact, v1, v2, v3, sub, frame_valid, line_num
  );
endinterface

// File: rtl/tim_vseq_pulse_cnt.sv
// -----------------------------------------------------------------------------
// tim_vseq_pulse_cnt
// Loadable down-counter with zero flag; times every phase of the sequencer
// (flush, exposure, transfer, vertical shift phases).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load_i         load load_val_i this cycle (takes priority over counting)
//   load_val_i     duration-1 of the phase being entered
//   zero_o         counter currently reads zero
// -----------------------------------------------------------------------------
module tim_vseq_pulse_cnt #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      // Saturate at zero so an idle counter keeps reporting expiry.
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tim_vseq.sv
// -----------------------------------------------------------------------------
// tim_vseq
// Vertical/frame sequencer for the CCD readout chain. A start request runs:
// substrate flush, exposure, photodiode->VCCD transfer, then for each line a
// two-phase vertical shift followed by a readout request (vact) to the
// horizontal FSM, retired by its line_done pulse. Leading NVDUM lines are
// dummies (frame_valid low). All outputs are registered from the next state.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        tim_vseq_if.slave: start/abort/exp_time/line_done in;
//              busy/done/vact/v1/v2/v3/sub/frame_valid/line_num out
// -----------------------------------------------------------------------------
module tim_vseq import tim_vseq_pkg::*; #(
  parameter int NLINES = NLINES_DEF,
  parameter int NVDUM  = NVDUM_DEF,
  parameter int TV     = TV_DEF,
  parameter int TXFER  = TXFER_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic     clk,
  input  logic     rst,
  tim_vseq_if.slave bus
);

  localparam logic [LNW-1:0] LAST_LINE = LNW'(NVDUM + NLINES - 1);
  localparam logic [LNW-1:0] FIRST_ACT = LNW'(NVDUM);
  localparam logic [CW-1:0]  TXFER_M1  = CW'(TXFER - 1);
  localparam logic [CW-1:0]  TV_M1     = CW'(TV - 1);

  vseq_state_t    state_q, state_d;
  logic [LNW-1:0] line_num_q, line_num_d;
  logic [CW-1:0]  exp_q, exp_d;
  vseq_outs_t     outs_q;
  logic           frame_valid_q;

  logic           cnt_load;
  logic [CW-1:0]  cnt_val;
  logic           cnt_zero;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    line_num_d = line_num_q;
    exp_d      = exp_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = ST_FLUSH;
          // A zero exposure still spends one cycle in EXPOSE.
          exp_d      = (bus.exp_time == '0) ? CW'(1) : bus.exp_time;
          line_num_d = '0;
        end
      end
      ST_FLUSH:  if (cnt_zero) state_d = ST_EXPOSE;
      ST_EXPOSE: if (cnt_zero) state_d = ST_XFER;
      ST_XFER:   if (cnt_zero) state_d = ST_VSH_A;
      ST_VSH_A:  if (cnt_zero) state_d = ST_VSH_B;
      ST_VSH_B:  if (cnt_zero) state_d = ST_LREAD;
      ST_LREAD: begin
        if (bus.line_done) begin
          if (line_num_q == LAST_LINE) begin
            state_d = ST_DONE;
          end else begin
            line_num_d = line_num_q + 1'b1;
            state_d    = ST_VSH_A;
          end
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Abort overrides every other request once a frame is under way.
    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
    end

    // Idle line index is 0 however IDLE was reached.
    if (state_d == ST_IDLE) begin
      line_num_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counter: reloaded with duration-1 on every state entry. Every timed
  // state is entered from a different state, so a state change marks entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_load = (state_d != state_q);
    cnt_val  = '0;
    case (state_d)
      ST_FLUSH:  cnt_val = TXFER_M1;
      ST_EXPOSE: cnt_val = exp_q - 1'b1;
      ST_XFER:   cnt_val = TXFER_M1;
      ST_VSH_A:  cnt_val = TV_M1;
      ST_VSH_B:  cnt_val = TV_M1;
      default:   cnt_val = '0;
    endcase
  end

  tim_vseq_pulse_cnt #(
    .CW (CW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      line_num_q    <= '0;
      exp_q         <= CW'(1);
      outs_q        <= state_outs(ST_IDLE);
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_num_q    <= line_num_d;
      exp_q         <= exp_d;
      outs_q        <= state_outs(state_d);
      frame_valid_q <= (state_d == ST_LREAD) && (line_num_d >= FIRST_ACT);
    end
  end

  assign bus.busy        = outs_q.busy;
  assign bus.done        = outs_q.done;
  assign bus.vact        = outs_q.vact;
  assign bus.v1          = outs_q.v1;
  assign bus.v2          = outs_q.v2;
  assign bus.v3          = outs_q.v3;
  assign bus.sub         = outs_q.sub;
  assign bus.frame_valid = frame_valid_q;
  assign bus.line_num    = line_num_q;

endmodule

// File: tb/tb_tim_vseq.sv
// -----------------------------------------------------------------------------
// tb_tim_vseq
// Directed bench for tim_vseq with NLINES=4 NVDUM=1 TV=2 TXFER=3 and a
// horizontal-FSM model that returns line_done 10 cycles after vact rises.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tim_vseq;

  localparam int CW = 24;
  localparam logic [19:0] IDLE_VEC = 20'h08000;  // only v2 high

  logic clk;
  logic rst;

  tim_vseq_if #(.CW(CW)) bus ();

  tim_vseq #(
    .NLINES (4),
    .NVDUM  (1),
    .TV     (2),
    .TXFER  (3),
    .CW     (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // per-frame statistics
  int   first_sub, n_sub, first_v3, n_v3, n_rise, n_done, done_cyc;
  int   rise_cyc [8];
  logic rise_fv  [8];
  logic [11:0] rise_ln [8];
  int   n_v1v2   = 0;
  int   n_v3nv1  = 0;
  logic vact_prev = 1'b0;
  logic v1_cur    = 1'b0;
  logic v1_last   = 1'b0;
  int   ld_cnt    = 0;
  logic start_spam = 1'b0;
  logic ld_spam    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] out_vec();
    return {bus.busy, bus.done, bus.vact, bus.v1, bus.v2, bus.v3, bus.sub,
            bus.frame_valid, bus.line_num};
  endfunction

  task automatic clr_stats();
    first_sub = -1; n_sub = 0; first_v3 = -1; n_v3 = 0;
    n_rise = 0; n_done = 0; done_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      rise_cyc[i] = -1; rise_fv[i] = 1'b0; rise_ln[i] = '0;
    end
  endtask

  // Advance one cycle, record outputs, run the horizontal FSM model.
  task automatic tick();
    logic ld;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.v1 && bus.v2) n_v1v2++;
    if (bus.v3 && !bus.v1) n_v3nv1++;
    if (bus.sub) begin
      if (n_sub == 0) first_sub = cyc;
      n_sub++;
    end
    if (bus.v3) begin
      if (n_v3 == 0) first_v3 = cyc;
      n_v3++;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    ld = 1'b0;
    if (bus.vact && !vact_prev) begin
      if (n_rise < 8) begin
        rise_cyc[n_rise] = cyc;
        rise_fv[n_rise]  = bus.frame_valid;
        rise_ln[n_rise]  = bus.line_num;
      end
      n_rise++;
      ld_cnt = 10;
    end else if (!bus.vact) begin
      ld_cnt = 0;
    end else if (ld_cnt > 0) begin
      ld_cnt--;
      if (ld_cnt == 0) ld = 1'b1;
    end
    vact_prev     = bus.vact;
    v1_last       = v1_cur;
    v1_cur        = bus.v1;
    // stray line_done while VSH_A is visible (v1 without v3)
    bus.line_done = ld | (ld_spam && bus.v1 && !bus.v3);
    if (start_spam) bus.start = bus.busy && (cyc % 7 == 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
  endtask

  task automatic start_frame(input logic [CW-1:0] e, output int t);
    clr_stats();
    t = cyc;
    bus.start    = 1'b1;
    bus.exp_time = e;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int k;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.exp_time  = '0;
    bus.line_done = 1'b0;
    clr_stats();

    // ---- 1: reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.abort     = 1'($urandom_range(0, 1));
      bus.exp_time  = CW'($urandom);
      bus.line_done = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("t1_rst_c%0d", i), 32'(out_vec()), 32'(IDLE_VEC));
    end
    rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.line_done = 1'b0;
    tick();
    check("t1_idle_after_rst", 32'(out_vec()), 32'(IDLE_VEC));

    // ---- 2: normal frame, exp_time=5
    start_frame(CW'(5), t);
    wait_done("t2", 200);
    $display("[TB] frame t2: %0d lines, done at +%0d", n_rise, done_cyc - t);
    check("t2_sub_first", 32'(first_sub - t), 32'd1);
    check("t2_sub_len", 32'(n_sub), 32'd3);
    check("t2_v3_first", 32'(first_v3 - t), 32'd9);
    check("t2_v3_len", 32'(n_v3), 32'd3);
    check("t2_lines", 32'(n_rise), 32'd5);
    check("t2_vact0_at", 32'(rise_cyc[0] - t), 32'd16);
    check("t2_line_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'd15);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_fv%0d", i), 32'(rise_fv[i]), 32'(i >= 1));
      check($sformatf("t2_ln%0d", i), 32'(rise_ln[i]), 32'(i));
    end
    check("t2_done_at", 32'(done_cyc - t), 32'd87);
    tick();
    check("t2_idle_after", 32'(out_vec()), 32'(IDLE_VEC));
    check("t2_single_done", 32'(n_done), 32'd1);

    // ---- 3: exp_time=0, started in the first IDLE cycle after DONE
    start_frame(CW'(0), t);
    wait_done("t3", 200);
    $display("[TB] frame t3: %0d lines, done at +%0d", n_rise, done_cyc - t);
    check("t3_restart_sub", 32'(first_sub - t), 32'd1);
    check("t3_v3_first", 32'(first_v3 - t), 32'd5);
    check("t3_done_at", 32'(done_cyc - t), 32'd83);

    // ---- 4: abort during LREAD of line 2, then a full frame
    tick();
    start_frame(CW'(5), t);
    k = 0;
    while (!(bus.vact && bus.line_num == 12'd2) && k < 100) begin
      tick();
      k++;
    end
    check("t4_reach_line2", 32'(bus.vact && bus.line_num == 12'd2), 32'd1);
    check("t4_line2_at", 32'(rise_cyc[2] - t), 32'd46);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t4_abort_idle", 32'(out_vec()), 32'(IDLE_VEC));
    repeat (30) tick();
    check("t4_no_done", 32'(n_done), 32'd0);
    $display("[TB] frame t4a: aborted at line 2");
    start_frame(CW'(5), t);
    wait_done("t4b", 200);
    $display("[TB] frame t4b: %0d lines, done at +%0d", n_rise, done_cyc - t);
    check("t4_first_line", 32'(rise_ln[0]), 32'd0);
    check("t4_lines", 32'(n_rise), 32'd5);
    check("t4_done_at", 32'(done_cyc - t), 32'd87);

    // ---- 5: stray start/line_done during a frame; start+abort in IDLE
    tick();
    start_spam = 1'b1;
    ld_spam    = 1'b1;
    clr_stats();
    t = cyc;
    bus.start    = 1'b1;
    bus.exp_time = CW'(5);
    tick();
    wait_done("t5", 200);
    start_spam = 1'b0;
    ld_spam    = 1'b0;
    bus.start  = 1'b0;
    $display("[TB] frame t5: %0d lines, done at +%0d", n_rise, done_cyc - t);
    check("t5_v3_first", 32'(first_v3 - t), 32'd9);
    check("t5_lines", 32'(n_rise), 32'd5);
    check("t5_done_at", 32'(done_cyc - t), 32'd87);
    tick();
    check("t5_idle", 32'(out_vec()), 32'(IDLE_VEC));
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("t5_sa_idle1", 32'(out_vec()), 32'(IDLE_VEC));
    tick();
    check("t5_sa_idle2", 32'(out_vec()), 32'(IDLE_VEC));

    // ---- 6: reset during VSH_B
    start_frame(CW'(5), t);
    k = 0;
    while (!(bus.v2 && bus.busy && v1_last) && k < 100) begin
      tick();
      k++;
    end
    check("t6_reach_vshb", 32'(cyc - t), 32'd14);
    rst = 1'b1;
    tick();
    check("t6_rst_vshb", 32'(out_vec()), 32'(IDLE_VEC));
    rst = 1'b0;
    tick();
    check("t6_idle_after", 32'(out_vec()), 32'(IDLE_VEC));
    $display("[TB] frame t6: reset in VSH_B");

    check("never_v1_v2", 32'(n_v1v2), 32'd0);
    check("never_v3_without_v1", 32'(n_v3nv1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
